first_match_window: RTL

//  Multi-channel bounded-window first_match checker, the hardware analogue of
//  "en |-> first_match(##[MIN_DLY:MAX_DLY] signal_in)".

---
 rtl/first_match_window.sv | 101 ++++++++++
 1 files changed

// File: rtl/first_match_window.sv
// first_match_window: per-channel bounded-window first-match checker with saturating match/fail totals
module first_match_window #(
  parameter int N_CH = 4,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 8,
  parameter int RETRIGGER = 0,
  parameter int CNT_OUT_W = 16,
  localparam int LAT_W = $clog2(MAX_DLY + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       signal_in,
  input  logic                  cnt_clr,
  output logic [N_CH-1:0]       match,
  output logic [N_CH-1:0]       fail,
  output logic [N_CH-1:0]       drop,
  output logic [N_CH-1:0]       busy,
  output logic [N_CH*LAT_W-1:0] lat,
  output logic [CNT_OUT_W-1:0]  match_cnt,
  output logic [CNT_OUT_W-1:0]  fail_cnt
);
  localparam int SUM_W = CNT_OUT_W + $clog2(N_CH + 1);
  localparam logic [LAT_W-1:0] MIN_D = LAT_W'(MIN_DLY);
  localparam logic [LAT_W-1:0] MAX_D = LAT_W'(MAX_DLY);
  localparam logic [LAT_W-1:0] ONE_D = LAT_W'(1);
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_OUT_W{1'b1}});
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state [N_CH];
  state_t state_next [N_CH];
  logic [LAT_W-1:0] d [N_CH];
  logic [LAT_W-1:0] d_next [N_CH];
  logic [N_CH-1:0] match_next, fail_next, drop_next;
  logic [N_CH*LAT_W-1:0] lat_next;
  logic [SUM_W-1:0] match_sum, fail_sum;
  if (MIN_DLY < 1 || MIN_DLY > MAX_DLY) begin : g_bad_dly
    $error("first_match_window: MIN_DLY must lie in 1..MAX_DLY");
  end
  always_comb begin
    match_next = '0;
    fail_next = '0;
    drop_next = '0;
    lat_next = lat;
    for (int i = 0; i < N_CH; i++) begin
      state_next[i] = state[i];
      d_next[i] = d[i];
      if (state[i] == IDLE) begin
        if (en[i]) begin
          state_next[i] = ACTIVE;
          d_next[i] = ONE_D;
        end
      end else if (en[i] && RETRIGGER != 0) begin
        d_next[i] = ONE_D;
        drop_next[i] = 1'b1;
      end else begin
        drop_next[i] = en[i];
        if (d[i] >= MIN_D && signal_in[i]) begin
          match_next[i] = 1'b1;
          lat_next[i*LAT_W +: LAT_W] = d[i];
          state_next[i] = IDLE;
        end else if (d[i] == MAX_D) begin
          fail_next[i] = 1'b1;
          state_next[i] = IDLE;
        end else begin
          d_next[i] = d[i] + ONE_D;
        end
      end
    end
    match_sum = SUM_W'(match_cnt) + SUM_W'($countones(match_next));
    fail_sum = SUM_W'(fail_cnt) + SUM_W'($countones(fail_next));
  end
  always_comb begin
    busy = '0;
    for (int i = 0; i < N_CH; i++) busy[i] = state[i] == ACTIVE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        state[i] <= IDLE;
        d[i] <= '0;
      end
      match <= '0;
      fail <= '0;
      drop <= '0;
      lat <= '0;
      match_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        state[i] <= state_next[i];
        d[i] <= d_next[i];
      end
      match <= match_next;
      fail <= fail_next;
      drop <= drop_next;
      lat <= lat_next;
      match_cnt <= cnt_clr ? '0 : (match_sum > CNT_MAX ? CNT_MAX[CNT_OUT_W-1:0] : match_sum[CNT_OUT_W-1:0]);
      fail_cnt <= cnt_clr ? '0 : (fail_sum > CNT_MAX ? CNT_MAX[CNT_OUT_W-1:0] : fail_sum[CNT_OUT_W-1:0]);
    end
  end
endmodule
